// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request record used by
// writeback arbiters and their benches.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  // Round-robin successor of a granted index, wrapping at n.
  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational rotating-priority arbiter: the search starts at ptr and
// wraps, so tying ptr to zero yields a fixed lowest-index-first arbiter.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_valid
);

  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = PTR_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback requesters with
// a registered output stage. Define REGFILE_ARB_FIXED_PRIO_EN for fixed priority.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Hold,
  input  logic [NUM_REQ-1:0]        Req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] Req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] Req_data,
  output logic [NUM_REQ-1:0]        Req_ready,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         WriteRegister,
  output logic [DATA_W-1:0]         WriteData,
  output logic [(2**ADDR_W)-1:0]    PendingMask
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [NREGS-1:0] ONE_HOT_BASE = NREGS'(1);

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_valid;
  logic [PTR_W-1:0]   arb_ptr;
  logic               transfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Hold masks the requests so the arbiter itself never sees them.
  assign arb_req = Hold ? '0 : Req_valid;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req         (arb_req),
    .ptr         (arb_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign Req_ready = Rst_n ? grant : '0;
  assign transfer  = grant_valid && Rst_n;
  assign sel_addr  = Req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_data  = Req_data[int'(grant_idx)*DATA_W +: DATA_W];

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [PTR_W-1:0] rr_ptr;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= PTR_W'(next_ptr(int'(grant_idx), NUM_REQ));
    end
  end

  assign arb_ptr = rr_ptr;
`endif

  // Writes to the zero register are consumed but never raise RegWrite.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (transfer) begin
      RegWrite      <= (sel_addr != ADDR_W'(ZERO_REG));
      WriteRegister <= sel_addr;
      WriteData     <= sel_data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

  assign PendingMask = RegWrite ? (ONE_HOT_BASE << WriteRegister) : '0;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter with a behavioural
// register file fed from the DUT write port.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic [31:0] rf [NUM_REGS];

  int total;
  int bad;

  regfile_write_arbiter #(
    .NUM_REQ (3),
    .ADDR_W  (5),
    .DATA_W  (32)
  ) dut (
    .Clk           (clk),
    .Rst_n         (rst_n),
    .Hold          (hold),
    .Req_valid     (req_valid),
    .Req_addr      (req_addr),
    .Req_data      (req_data),
    .Req_ready     (req_ready),
    .RegWrite      (reg_write),
    .WriteRegister (write_register),
    .WriteData     (write_data),
    .PendingMask   (pending_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;
  end

  always @(posedge clk) begin
    if (reg_write) rf[write_register] <= write_data;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setReq(input int idx, input logic [4:0] addr, input logic [31:0] data);
    wb_req_t r;
    r.valid = 1'b1;
    r.addr  = addr;
    r.data  = data;
    req_addr[idx*5 +: 5]   = r.addr;
    req_data[idx*32 +: 32] = r.data;
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic hold_in);
    req_valid = valid;
    hold      = hold_in;
  endtask

  task automatic checkStage(input string tag, input logic wr, input logic [4:0] addr,
                            input logic [31:0] data);
    checkOutput({tag, "_regwrite"}, 64'(reg_write), 64'(wr));
    checkOutput({tag, "_addr"}, 64'(write_register), 64'(addr));
    checkOutput({tag, "_data"}, 64'(write_data), 64'(data));
    checkOutput({tag, "_pending"}, 64'(pending_mask),
                wr ? (64'd1 << addr) : 64'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    req_addr = '0;
    req_data = '0;
    applyStimulus(3'b000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkStage("reset", 1'b0, 5'd0, 32'd0);
    checkOutput("reset_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stage a write to reg 8, then reset asynchronously before it commits.
    setReq(0, 5'd8, 32'h55);
    applyStimulus(3'b001, 1'b0);
    #1 checkOutput("pre_reset_ready", 64'(req_ready), 64'b001);
    @(negedge clk);
    applyStimulus(3'b000, 1'b0);
    #1 checkStage("staged_reg8", 1'b1, 5'd8, 32'h55);
    #2;
    rst_n = 1'b0;
    applyStimulus(3'b010, 1'b0);
    #1;
    checkOutput("midreset_regwrite", 64'(reg_write), 64'd0);
    checkOutput("midreset_pending", 64'(pending_mask), 64'd0);
    checkOutput("midreset_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    setReq(0, 5'd3, 32'h30);
    setReq(1, 5'd4, 32'h40);
    applyStimulus(3'b011, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1 checkOutput("fixed_ready", 64'(req_ready), 64'b001);
      @(negedge clk);
      #1 checkStage("fixed_stage", 1'b1, 5'd3, 32'h30);
    end
    applyStimulus(3'b000, 1'b0);
`else
    // Round-robin with all three requesters valid.
    setReq(0, 5'd16, 32'd2);
    setReq(1, 5'd17, 32'd3);
    setReq(2, 5'd18, 32'd4);
    applyStimulus(3'b111, 1'b0);
    #1;
    checkOutput("rr_ready0", 64'(req_ready), 64'b001);
    checkOutput("rf8_discarded", 64'(rf[8]), 64'd0);
    @(negedge clk);
    #1;
    checkStage("rr_stage16", 1'b1, 5'd16, 32'd2);
    checkOutput("rr_ready1", 64'(req_ready), 64'b010);
    @(negedge clk);
    #1;
    checkStage("rr_stage17", 1'b1, 5'd17, 32'd3);
    checkOutput("rr_ready2", 64'(req_ready), 64'b100);
    @(negedge clk);
    #1;
    checkStage("rr_stage18", 1'b1, 5'd18, 32'd4);
    checkOutput("rr_ready_wrap", 64'(req_ready), 64'b001);
    applyStimulus(3'b000, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("rr_idle_regwrite", 64'(reg_write), 64'd0);
    checkOutput("rr_idle_pending", 64'(pending_mask), 64'd0);
    checkOutput("rf16", 64'(rf[16]), 64'd2);
    checkOutput("rf17", 64'(rf[17]), 64'd3);
    checkOutput("rf18", 64'(rf[18]), 64'd4);

    // Zero register write from requester 1 (pointer is 0 here).
    setReq(1, 5'd0, 32'hFFFF_FFFF);
    applyStimulus(3'b010, 1'b0);
    #1 checkOutput("zero_ready", 64'(req_ready), 64'b010);
    @(negedge clk);
    #1 checkStage("zero_stage", 1'b0, 5'd0, 32'hFFFF_FFFF);

    // Collision on reg 8: pointer is 2, so requester 2 goes first.
    setReq(0, 5'd8, 32'd10);
    setReq(2, 5'd8, 32'd20);
    applyStimulus(3'b101, 1'b0);
    #1 checkOutput("coll_ready_first", 64'(req_ready), 64'b100);
    @(negedge clk);
    applyStimulus(3'b001, 1'b0);
    #1;
    checkStage("coll_stage20", 1'b1, 5'd8, 32'd20);
    checkOutput("coll_ready_second", 64'(req_ready), 64'b001);
    checkOutput("rf0_const", 64'(rf[0]), 64'd0);
    @(negedge clk);
    applyStimulus(3'b000, 1'b0);
    #1 checkStage("coll_stage10", 1'b1, 5'd8, 32'd10);
    @(negedge clk);
    #1 checkOutput("rf8_final", 64'(rf[8]), 64'd10);

    // Hold with one write staged and all requesters pending; pointer is 1.
    setReq(1, 5'd5, 32'h77);
    applyStimulus(3'b010, 1'b0);
    #1 checkOutput("hold_pre_ready", 64'(req_ready), 64'b010);
    @(negedge clk);
    setReq(0, 5'd20, 32'hA0);
    setReq(1, 5'd21, 32'hA1);
    setReq(2, 5'd22, 32'hA2);
    applyStimulus(3'b111, 1'b1);
    #1;
    checkStage("hold_staged", 1'b1, 5'd5, 32'h77);
    checkOutput("hold_ready_c0", 64'(req_ready), 64'd0);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      #1;
      checkOutput("hold_ready", 64'(req_ready), 64'd0);
      checkOutput("hold_regwrite", 64'(reg_write), 64'd0);
      checkOutput("hold_pending", 64'(pending_mask), 64'd0);
    end
    @(negedge clk);
    applyStimulus(3'b111, 1'b0);
    #1;
    checkOutput("rf5_hold_commit", 64'(rf[5]), 64'h77);
    checkOutput("resume_ready", 64'(req_ready), 64'b100);
    @(negedge clk);
    applyStimulus(3'b000, 1'b0);
    #1 checkStage("resume_stage22", 1'b1, 5'd22, 32'hA2);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
